nand_dqs_calib: RTL and testbench
=================================

# nand_dqs_calib

Multi-channel read-capture calibration engine for the NAND PHY. On request, it sweeps the IDELAY tap of every channel's DQS in lockstep. At each tap it checks the captured rise-edge DQ word against a fixed training pattern, then finds the longest passing tap window per channel. It finishes by loading each channel's window centre. It sits between the flash controller and NUM_CH PHY instances, driving their `dlyval_dqs`/`dlyld_dqs` inputs.

## Interface
Parameters:
- NUM_CH, 4, number of independent NAND buses/PHYs calibrated together
- DQ_WIDTH, 8, DQ bits per channel
- TAP_W, 5, delay tap value width; sweep covers 0..2^TAP_W-1
- SETTLE_CYC, 16, wait cycles after each delay load before sampling (≥1)
- SAMPLES, 8, training words compared per tap (≥1)
- PATTERN, 8'hA5, expected training word (DQ_WIDTH bits)

Ports:
- clk0  in  1  single clock; all logic on rising edge
- rst0  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy
- sample_valid  in  1  all channels' sample words hold a fresh training word this cycle
- sample  in  NUM_CH*DQ_WIDTH  captured rise data, channel c at [c*DQ_WIDTH +: DQ_WIDTH]
- dlyval  out  NUM_CH*TAP_W  delay value per channel
- dlyld  out  NUM_CH  one-cycle load strobe per channel
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- ch_fail  out  NUM_CH  channel had no passing tap; valid from done until next start
- ch_tap  out  NUM_CH*TAP_W  final tap per channel; valid with ch_fail

## Operation
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, FINAL, DONE.
- IDLE→LOAD on start: tap←0, per-channel cur_run/best_len/best_start cleared, ch_fail cleared.
- LOAD (1 cycle): dlyval=tap on all channels, dlyld=all ones → SETTLE.
- SETTLE: count SETTLE_CYC cycles → SAMPLE.
- SAMPLE: accept SAMPLES sample_valid beats. Per channel, pass &= (sample==PATTERN). sample_valid outside SAMPLE is ignored. No timeout; the controller must keep supplying reads.
- EVAL (1 cycle), per channel:
  - if pass: cur_start←tap when cur_run==0; cur_run++; if cur_run+1 > best_len then best_len←cur_run+1 and best_start←cur_start (strict >, so the first longest window wins).
  - else: cur_run←0.
  - Then, if tap==max → FINAL; else tap++ → LOAD.
- FINAL (1 cycle):
  - ch_tap = best_start + ((best_len-1)>>1).
  - best_len==0 → ch_fail=1 and ch_tap=0.
  - Drive dlyval=ch_tap with dlyld all ones. Failed channels are loaded with 0.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- Width rules: run/len counters TAP_W+1 bits, because a full window is 2^TAP_W. The centre sum always fits TAP_W and never wraps.
- A window touching tap max is valid. An all-pass sweep gives centre 2^(TAP_W-1)-1.

## Timing
- Reset values: dlyval=0, dlyld=0, busy=0, done=0, ch_fail=0, ch_tap=0. State goes to IDLE.
- Reset mid-sweep aborts immediately with no further dlyld. The delay element keeps its last loaded value.
- busy rises the cycle after start is sampled in IDLE.
- dlyld is high exactly 2^TAP_W+1 times per run.
- Minimum run length: 2^TAP_W*(2+SETTLE_CYC+SAMPLES)+2 cycles, with sample_valid held high.
- start coincident with done is ignored; start in IDLE is accepted the next cycle.
- All outputs are registered.

## Structure
- Shared package nand_phy_pkg: state enum, TAP_W default, training PATTERN constant. The controller uses the same pattern.
- One sub-module, nand_dqs_calib_ch: per-channel pass accumulator, run/best tracking and centre computation, instantiated NUM_CH times.
- The top level holds the FSM, tap counter and settle/sample counters.

## Test plan
- Channel 0 passes taps 10..20 only, others fail all taps → ch_tap[0]=15, ch_fail=4'b1110, done pulse once.
- Channel 1 passes taps 2..5 and 12..15 (equal length) → ch_tap[1]=3, so the first window wins.
- All taps pass on every channel → ch_tap=15 for all (TAP_W=5); window reaching tap 31 is handled without overflow.
- One mismatching word among the 8 samples at tap 7, all other taps pass → tap 7 fails; windows 0..6 and 8..31 give ch_tap=19.
- Count dlyld strobes over one run → exactly 33 per channel; SETTLE_CYC gap observed after each load.
- Assert rst0 during SAMPLE at tap 9 → next cycle all outputs are 0 with no extra dlyld; a following start runs a full correct sweep.

Source files
------------

// File: rtl/nand_phy_pkg.sv
// Shared NAND PHY definitions: calibration state encoding, default tap width
// and the training word that the flash controller also drives during reads.
package nand_phy_pkg;

    localparam int TAP_W_DEF = 5;
    localparam logic [7:0] TRAIN_PATTERN = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_FINAL,
        ST_DONE
    } calib_state_t;

endpackage

// File: rtl/nand_dqs_calib_ch.sv
// Per-channel DQS calibration tracker: accumulates pass/fail for the current tap,
// tracks the longest passing tap window and computes its centre.
module nand_dqs_calib_ch #(
    parameter int                  DQ_WIDTH = 8,
    parameter int                  TAP_W    = 5,
    parameter logic [DQ_WIDTH-1:0] PATTERN  = 8'hA5
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic                clear,
    input  logic                arm,
    input  logic                beat,
    input  logic                eval,
    input  logic [TAP_W-1:0]    tap,
    input  logic [DQ_WIDTH-1:0] sample,
    output logic [TAP_W-1:0]    centre,
    output logic                no_window
);

    // Run/length counters are one bit wider than a tap: a full window spans 2^TAP_W taps.
    logic             pass;
    logic [TAP_W:0]   cur_run;
    logic [TAP_W:0]   best_len;
    logic [TAP_W-1:0] cur_start;
    logic [TAP_W-1:0] best_start;

    logic [TAP_W:0]   run_inc;
    logic [TAP_W-1:0] start_eff;
    logic [TAP_W:0]   len_m1;

    always_comb begin
        run_inc   = cur_run + 1'b1;
        start_eff = (cur_run == '0) ? tap : cur_start;
        len_m1    = best_len - 1'b1;
        no_window = (best_len == '0);
        centre    = no_window ? '0 : best_start + TAP_W'(len_m1 >> 1);
    end

    always_ff @(posedge clk0) begin
        if (rst0 || clear) begin
            pass       <= 1'b0;
            cur_run    <= '0;
            best_len   <= '0;
            cur_start  <= '0;
            best_start <= '0;
        end else begin
            if (arm) begin
                pass <= 1'b1;
            end else if (beat && (sample != PATTERN)) begin
                pass <= 1'b0;
            end

            if (eval) begin
                if (pass) begin
                    cur_start <= start_eff;
                    cur_run   <= run_inc;
                    // Strict compare keeps the earliest of equally long windows.
                    if (run_inc > best_len) begin
                        best_len   <= run_inc;
                        best_start <= start_eff;
                    end
                end else begin
                    cur_run <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/nand_dqs_calib.sv
// Multi-channel DQS read-capture calibration: sweeps every tap on all channels in
// lockstep, scores each tap against the training word, then loads window centres.
module nand_dqs_calib
    import nand_phy_pkg::*;
#(
    parameter int                  NUM_CH     = 4,
    parameter int                  DQ_WIDTH   = 8,
    parameter int                  TAP_W      = TAP_W_DEF,
    parameter int                  SETTLE_CYC = 16,
    parameter int                  SAMPLES    = 8,
    parameter logic [DQ_WIDTH-1:0] PATTERN    = DQ_WIDTH'(TRAIN_PATTERN)
) (
    input  logic                       clk0,
    input  logic                       rst0,
    input  logic                       start,
    input  logic                       sample_valid,
    input  logic [NUM_CH*DQ_WIDTH-1:0] sample,
    output logic [NUM_CH*TAP_W-1:0]    dlyval,
    output logic [NUM_CH-1:0]          dlyld,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_CH-1:0]          ch_fail,
    output logic [NUM_CH*TAP_W-1:0]    ch_tap,
    output calib_state_t               dbg_state
);

    // Handshakes: start is a single-cycle request taken only in IDLE; sample_valid
    // qualifies one beat of sample per cycle in SAMPLE, with no backpressure path.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int SMP_W = $clog2(SAMPLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES - 1);
    localparam logic [TAP_W-1:0] TAP_MAX  = '1;

    calib_state_t state, state_next;
    logic [TAP_W-1:0] tap, tap_next;
    logic [SET_W-1:0] settle_cnt;
    logic [SMP_W-1:0] sample_cnt;

    logic                    clear;
    logic                    beat;
    logic [NUM_CH*TAP_W-1:0] centre_flat;
    logic [NUM_CH-1:0]       no_win;

    assign dbg_state = state;
    assign clear     = (state == ST_IDLE) && start;
    assign beat      = (state == ST_SAMPLE) && sample_valid;

    always_comb begin
        state_next = state;
        tap_next   = tap;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    tap_next   = '0;
                end
            end
            ST_LOAD:   state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SET_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: if (sample_valid && (sample_cnt == SMP_LAST)) state_next = ST_EVAL;
            ST_EVAL: begin
                if (tap == TAP_MAX) begin
                    state_next = ST_FINAL;
                end else begin
                    state_next = ST_LOAD;
                    tap_next   = tap + 1'b1;
                end
            end
            ST_FINAL: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up with its state.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state      <= ST_IDLE;
            tap        <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            dlyval     <= '0;
            dlyld      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ch_fail    <= '0;
            ch_tap     <= '0;
        end else begin
            state      <= state_next;
            tap        <= tap_next;
            dlyld      <= '0;
            busy       <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done       <= (state_next == ST_DONE);
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;

            if (state != ST_SAMPLE) begin
                sample_cnt <= '0;
            end else if (sample_valid) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            if (clear) begin
                ch_fail <= '0;
                ch_tap  <= '0;
            end

            if (state_next == ST_LOAD) begin
                dlyld  <= '1;
                dlyval <= {NUM_CH{tap_next}};
            end

            // Failed channels have a zero centre, so they are parked at tap 0.
            if (state == ST_FINAL) begin
                dlyld   <= '1;
                dlyval  <= centre_flat;
                ch_tap  <= centre_flat;
                ch_fail <= no_win;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        nand_dqs_calib_ch #(
            .DQ_WIDTH (DQ_WIDTH),
            .TAP_W    (TAP_W),
            .PATTERN  (PATTERN)
        ) u_ch (
            .clk0      (clk0),
            .rst0      (rst0),
            .clear     (clear),
            .arm       (state == ST_LOAD),
            .beat      (beat),
            .eval      (state == ST_EVAL),
            .tap       (tap),
            .sample    (sample[c*DQ_WIDTH +: DQ_WIDTH]),
            .centre    (centre_flat[c*TAP_W +: TAP_W]),
            .no_window (no_win[c])
        );
    end

endmodule

// File: tb/tb_nand_dqs_calib.sv
// Directed bench for nand_dqs_calib: a PHY model answers with per-tap pass maps,
// a scoreboard queue holds the expected result of each sweep until done appears.
module tb_nand_dqs_calib;
  import nand_phy_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DQ_WIDTH = 8;
  localparam int TAP_W = 5;
  localparam int SETTLE_CYC = 16;
  localparam int SAMPLES = 8;
  localparam int EW = NUM_CH + NUM_CH * TAP_W;
  localparam logic [DQ_WIDTH-1:0] PAT = 8'hA5;

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  logic start = 1'b0;
  logic sample_valid = 1'b1;
  logic [NUM_CH*DQ_WIDTH-1:0] sample = '0;
  logic [NUM_CH*TAP_W-1:0] dlyval;
  logic [NUM_CH-1:0] dlyld;
  logic busy;
  logic done;
  logic [NUM_CH-1:0] ch_fail;
  logic [NUM_CH*TAP_W-1:0] ch_tap;
  calib_state_t dbg_state;

  nand_dqs_calib #(
    .NUM_CH(NUM_CH), .DQ_WIDTH(DQ_WIDTH), .TAP_W(TAP_W),
    .SETTLE_CYC(SETTLE_CYC), .SAMPLES(SAMPLES), .PATTERN(PAT)
  ) dut (
    .clk0(clk0), .rst0(rst0), .start(start), .sample_valid(sample_valid),
    .sample(sample), .dlyval(dlyval), .dlyld(dlyld), .busy(busy), .done(done),
    .ch_fail(ch_fail), .ch_tap(ch_tap), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk0 = ~clk0;

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] pmap[NUM_CH];
  logic [NUM_CH-1:0] corrupt_ch = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PHY model: follows the last loaded tap; optionally spoils one beat at tap 7
  int cur_tap = 0;
  int since_ld = 0;
  always @(negedge clk0) begin
    logic ok;
    if (dlyld[0]) begin
      cur_tap = int'(dlyval[TAP_W-1:0]);
      since_ld = 0;
    end else begin
      since_ld++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      ok = pmap[c][cur_tap];
      if (corrupt_ch[c] && cur_tap == 7 && since_ld == 20) ok = 1'b0;
      sample[c*DQ_WIDTH +: DQ_WIDTH] = ok ? PAT : ~PAT;
    end
  end

  // monitor / scoreboard
  int ld_cnt = 0;
  int min_gap = 1000000;
  int cyc = 0;
  int last_ld = 0;
  always @(negedge clk0) begin
    logic [EW-1:0] e;
    cyc++;
    if (rst0) begin
      ld_cnt = 0;
      min_gap = 1000000;
    end else begin
      if (dlyld != '0) begin
        check("dlyld_all_channels", 64'(dlyld), 64'({NUM_CH{1'b1}}));
        if (ld_cnt > 0 && (cyc - last_ld) < min_gap) min_gap = cyc - last_ld;
        last_ld = cyc;
        ld_cnt++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("ch_tap", 64'(ch_tap), 64'(e[NUM_CH*TAP_W-1:0]));
          check("ch_fail", 64'(ch_fail), 64'(e[EW-1 -: NUM_CH]));
          check("final_dlyval", 64'(dlyval), 64'(e[NUM_CH*TAP_W-1:0]));
          check("dlyld_count", 64'(ld_cnt), 64'((1 << TAP_W) + 1));
          check("load_gap", 64'(min_gap), 64'(2 + SETTLE_CYC + SAMPLES));
          check("busy_low_at_done", 64'(busy), 64'(0));
        end
        ld_cnt = 0;
        min_gap = 1000000;
      end
    end
  end

  // driver tasks
  task automatic set_map(input logic [31:0] m0, input logic [31:0] m1,
                         input logic [31:0] m2, input logic [31:0] m3);
    pmap[0] = m0;
    pmap[1] = m1;
    pmap[2] = m2;
    pmap[3] = m3;
  endtask

  task automatic do_run(input logic [NUM_CH*TAP_W-1:0] et, input logic [NUM_CH-1:0] ef,
                        input bit coincident);
    int n;
    exp_q.push_back({ef, et});
    start = 1'b1;
    @(negedge clk0);
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'(1));
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk0);
      n++;
    end
    if (!done) begin
      check("done_timeout", 64'(done), 64'(1));
      exp_q.delete();
    end else begin
      if (coincident) start = 1'b1;
      @(negedge clk0);
      start = 1'b0;
      check("done_single_pulse", 64'(done), 64'(0));
      check("busy_after_done", 64'(busy), 64'(0));
      @(negedge clk0);
      check("start_at_done_ignored", 64'(busy), 64'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dlyval"}, 64'(dlyval), 64'(0));
    check({tag, "_dlyld"}, 64'(dlyld), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_ch_fail"}, 64'(ch_fail), 64'(0));
    check({tag, "_ch_tap"}, 64'(ch_tap), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    int n;
    int extra;
    set_map('0, '0, '0, '0);
    rst0 = 1'b1;
    repeat (3) @(negedge clk0);
    check_all_zero("reset");
    rst0 = 1'b0;
    @(negedge clk0);

    // ch0 window 10..20 -> 15, other channels never pass
    set_map(32'h001F_FC00, '0, '0, '0);
    do_run({5'd0, 5'd0, 5'd0, 5'd15}, 4'b1110, 1'b1);

    // two equal windows on ch1 (first wins), single tap 31 on ch2, single tap 0 on ch3
    set_map(32'hFFFF_FFFF, 32'h0000_F03C, 32'h8000_0000, 32'h0000_0001);
    do_run({5'd0, 5'd31, 5'd3, 5'd15}, 4'b0000, 1'b0);

    // full-width window on every channel
    set_map('1, '1, '1, '1);
    do_run({5'd15, 5'd15, 5'd15, 5'd15}, 4'b0000, 1'b0);

    // one bad beat at tap 7 on ch0 and ch2 splits their window into 0..6 and 8..31
    corrupt_ch = 4'b0101;
    do_run({5'd15, 5'd19, 5'd15, 5'd19}, 4'b0000, 1'b0);
    corrupt_ch = '0;

    // reset during SAMPLE at tap 9
    set_map('1, '1, '1, '1);
    start = 1'b1;
    @(negedge clk0);
    start = 1'b0;
    n = 0;
    while (!(dlyld[0] && dlyval[TAP_W-1:0] == 5'd9) && n < 2000) begin
      @(negedge clk0);
      n++;
    end
    check("reached_tap9_load", 64'(dlyval[TAP_W-1:0]), 64'(9));
    repeat (20) @(negedge clk0);
    check("in_sample_at_tap9", 64'(dbg_state), 64'(ST_SAMPLE));
    rst0 = 1'b1;
    @(negedge clk0);
    check_all_zero("midrun_reset");
    rst0 = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk0);
      if (dlyld != '0) extra++;
    end
    check("no_dlyld_after_abort", 64'(extra), 64'(0));

    // a fresh sweep after the abort
    set_map(32'hFFFF_FFFF, 32'h0000_F03C, 32'h8000_0000, 32'h0000_0001);
    do_run({5'd0, 5'd31, 5'd3, 5'd15}, 4'b0000, 1'b0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
